// File: rtl/corr_peak_select_if.sv
// Stream bundle between the 2x2 correlator, the peak selector and the phase/angle stage.
// master drives the correlator samples and threshold; slave is the peak selector.
interface corr_peak_select_if #(
  parameter int DIN_WIDTH = 32,
  parameter int IDX_WIDTH = 6
);
  logic                 sync_in;
  logic                 din_valid;
  logic [DIN_WIDTH-1:0] r11;
  logic [DIN_WIDTH-1:0] r22;
  logic [DIN_WIDTH-1:0] r12_re;
  logic [DIN_WIDTH-1:0] r12_im;
  logic [DIN_WIDTH:0]   thresh;
  logic [IDX_WIDTH-1:0] peak_idx;
  logic [DIN_WIDTH:0]   peak_pow;
  logic [DIN_WIDTH-1:0] peak_re;
  logic [DIN_WIDTH-1:0] peak_im;
  logic                 peak_found;
  logic                 dout_valid;

  modport master (
    output sync_in, din_valid, r11, r22, r12_re, r12_im, thresh,
    input  peak_idx, peak_pow, peak_re, peak_im, peak_found, dout_valid
  );

  modport slave (
    input  sync_in, din_valid, r11, r22, r12_re, r12_im, thresh,
    output peak_idx, peak_pow, peak_re, peak_im, peak_found, dout_valid
  );
endinterface

// File: rtl/corr_peak_select.sv
// Frame-wise peak search: picks the channel with the largest r11+r22 in each
// frame and reports its index, power and cross-correlation at frame end.
module corr_peak_select #(
  parameter int DIN_WIDTH  = 32,
  parameter int VECTOR_LEN = 64,
  parameter int IDX_WIDTH  = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  corr_peak_select_if.slave  bus
);
  localparam logic [IDX_WIDTH-1:0] LAST_CH = IDX_WIDTH'(VECTOR_LEN - 1);

  logic [IDX_WIDTH-1:0] cnt_reg;

  logic                 s1_valid_reg;
  logic [IDX_WIDTH-1:0] s1_idx_reg;
  logic [DIN_WIDTH:0]   s1_pow_reg;
  logic [DIN_WIDTH-1:0] s1_re_reg;
  logic [DIN_WIDTH-1:0] s1_im_reg;

  logic [IDX_WIDTH-1:0] max_idx_reg;
  logic [DIN_WIDTH:0]   max_pow_reg;
  logic [DIN_WIDTH-1:0] max_re_reg;
  logic [DIN_WIDTH-1:0] max_im_reg;

  logic [IDX_WIDTH-1:0] peak_idx_reg;
  logic [DIN_WIDTH:0]   peak_pow_reg;
  logic [DIN_WIDTH-1:0] peak_re_reg;
  logic [DIN_WIDTH-1:0] peak_im_reg;
  logic                 peak_found_reg;
  logic                 dout_valid_reg;

  logic                 sync_eff;
  logic [IDX_WIDTH-1:0] ch_cur;
  logic                 s2_live;
  logic                 s2_take;
  logic                 frame_end;
  logic [IDX_WIDTH-1:0] sel_idx;
  logic [DIN_WIDTH:0]   sel_pow;
  logic [DIN_WIDTH-1:0] sel_re;
  logic [DIN_WIDTH-1:0] sel_im;

  always_comb begin
    // A sync with the counter at 0 lands on a frame boundary: the channel
    // VECTOR_LEN-1 sample still in S1 must complete its frame normally.
    sync_eff  = bus.sync_in && (cnt_reg != '0);
    ch_cur    = bus.sync_in ? '0 : cnt_reg;
    s2_live   = s1_valid_reg && !sync_eff;
    s2_take   = s2_live && ((s1_idx_reg == '0) || (s1_pow_reg > max_pow_reg));
    frame_end = s2_live && (s1_idx_reg == LAST_CH);
    sel_idx   = s2_take ? s1_idx_reg : max_idx_reg;
    sel_pow   = s2_take ? s1_pow_reg : max_pow_reg;
    sel_re    = s2_take ? s1_re_reg  : max_re_reg;
    sel_im    = s2_take ? s1_im_reg  : max_im_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg        <= '0;
      s1_valid_reg   <= 1'b0;
      s1_idx_reg     <= '0;
      s1_pow_reg     <= '0;
      s1_re_reg      <= '0;
      s1_im_reg      <= '0;
      max_idx_reg    <= '0;
      max_pow_reg    <= '0;
      max_re_reg     <= '0;
      max_im_reg     <= '0;
      peak_idx_reg   <= '0;
      peak_pow_reg   <= '0;
      peak_re_reg    <= '0;
      peak_im_reg    <= '0;
      peak_found_reg <= 1'b0;
      dout_valid_reg <= 1'b0;
    end else begin
      if (bus.din_valid) begin
        cnt_reg <= (ch_cur == LAST_CH) ? '0 : ch_cur + IDX_WIDTH'(1);
      end else if (bus.sync_in) begin
        cnt_reg <= '0;
      end

      s1_valid_reg <= bus.din_valid;
      if (bus.din_valid) begin
        s1_idx_reg <= ch_cur;
        s1_pow_reg <= {1'b0, bus.r11} + {1'b0, bus.r22};
        s1_re_reg  <= bus.r12_re;
        s1_im_reg  <= bus.r12_im;
      end

      if (s2_take) begin
        max_idx_reg <= s1_idx_reg;
        max_pow_reg <= s1_pow_reg;
        max_re_reg  <= s1_re_reg;
        max_im_reg  <= s1_im_reg;
      end

      // The result includes the last channel itself, so take the selected
      // value rather than the running max register.
      dout_valid_reg <= frame_end;
      if (frame_end) begin
        peak_idx_reg   <= sel_idx;
        peak_pow_reg   <= sel_pow;
        peak_re_reg    <= sel_re;
        peak_im_reg    <= sel_im;
        peak_found_reg <= (sel_pow > bus.thresh);
      end
    end
  end

  assign bus.peak_idx   = peak_idx_reg;
  assign bus.peak_pow   = peak_pow_reg;
  assign bus.peak_re    = peak_re_reg;
  assign bus.peak_im    = peak_im_reg;
  assign bus.peak_found = peak_found_reg;
  assign bus.dout_valid = dout_valid_reg;
endmodule

// File: tb/tb_corr_peak_select.sv
// Randomized bench for corr_peak_select: frame-level reference model with a
// per-cycle output compare plus literal checks for the directed scenarios.
module tb_corr_peak_select;
  localparam int DW = 32;
  localparam int VL = 64;
  localparam int IW = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  corr_peak_select_if #(.DIN_WIDTH(DW), .IDX_WIDTH(IW)) bus ();

  corr_peak_select #(.DIN_WIDTH(DW), .VECTOR_LEN(VL), .IDX_WIDTH(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int              due;
    logic [IW-1:0]   idx;
    logic [DW:0]     pow;
    logic [DW-1:0]   re;
    logic [DW-1:0]   im;
    logic            found;
  } res_t;

  int vectors = 0;
  int miscompares = 0;
  int pc = 0;
  res_t pending[$];
  res_t cur_exp;
  logic [DW:0]   fpow[VL];
  logic [DW-1:0] fre[VL];
  logic [DW-1:0] fim[VL];
  int n = 0;
  int dv_count = 0;
  int last_dv_pc = -1;
  int prev_dv_pc = -1;

  always @(posedge clk) pc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, pc, act, exp);
    end
  endtask

  // Per-cycle compare against the frame model.
  always @(negedge clk) begin
    logic exp_dv;
    exp_dv = 1'b0;
    if (rst_n === 1'b1) begin
      if (pending.size() > 0 && pending[0].due == pc) begin
        cur_exp = pending.pop_front();
        exp_dv  = 1'b1;
      end
    end
    chk("dout_valid", 64'(bus.dout_valid), 64'(exp_dv));
    chk("peak_idx",   64'(bus.peak_idx),   64'(cur_exp.idx));
    chk("peak_pow",   64'(bus.peak_pow),   64'(cur_exp.pow));
    chk("peak_re",    64'(bus.peak_re),    64'(cur_exp.re));
    chk("peak_im",    64'(bus.peak_im),    64'(cur_exp.im));
    chk("peak_found", 64'(bus.peak_found), 64'(cur_exp.found));
    if (bus.dout_valid === 1'b1) begin
      dv_count++;
      prev_dv_pc = last_dv_pc;
      last_dv_pc = pc;
    end
  end

  // Frame model: collect accepted samples, emit argmax (lowest index on ties).
  task automatic model_step(input logic v, input logic s, input logic [DW-1:0] a,
                            input logic [DW-1:0] b, input logic [DW-1:0] re,
                            input logic [DW-1:0] im);
    res_t r;
    int best;
    if (s && n != 0) n = 0;
    if (v) begin
      fpow[n] = {1'b0, a} + {1'b0, b};
      fre[n]  = re;
      fim[n]  = im;
      n++;
      if (n == VL) begin
        best = 0;
        for (int i = 1; i < VL; i++) if (fpow[i] > fpow[best]) best = i;
        r.due   = pc + 2;
        r.idx   = IW'(best);
        r.pow   = fpow[best];
        r.re    = fre[best];
        r.im    = fim[best];
        r.found = (fpow[best] > bus.thresh);
        pending.push_back(r);
        n = 0;
      end
    end
  endtask

  task automatic step(input logic v, input logic s, input logic [DW-1:0] a,
                      input logic [DW-1:0] b, input logic [DW-1:0] re,
                      input logic [DW-1:0] im);
    bus.din_valid = v;
    bus.sync_in   = s;
    bus.r11       = a;
    bus.r22       = b;
    bus.r12_re    = re;
    bus.r12_im    = im;
    model_step(v, s, a, b, re, im);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic hold_reset(input int cycles);
    rst_n = 1'b0;
    pending.delete();
    n = 0;
    cur_exp = '{default: '0};
    #1;
    chk("rst_dout_valid", 64'(bus.dout_valid), 64'd0);
    chk("rst_peak_pow",   64'(bus.peak_pow),   64'd0);
    chk("rst_peak_idx",   64'(bus.peak_idx),   64'd0);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, '0, '0, '0, '0);
    rst_n = 1'b1;
  endtask

  initial begin
    int last_pc;
    int dv_before;
    logic [DW-1:0] a, b;
    cur_exp        = '{default: '0};
    rst_n          = 1'b0;
    bus.din_valid  = 1'b0;
    bus.sync_in    = 1'b0;
    bus.r11        = '0;
    bus.r22        = '0;
    bus.r12_re     = '0;
    bus.r12_im     = '0;
    bus.thresh     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // 1: ramp frame, peak at the last channel.
    for (int ch = 0; ch < VL; ch++) begin
      last_pc = pc;
      step(1'b1, 1'b0, DW'(ch * 5), DW'(ch * 5), DW'(ch), DW'(-ch));
    end
    idle(4);
    chk("t1_latency", 64'(last_dv_pc), 64'(last_pc + 2));
    chk("t1_idx",   64'(bus.peak_idx), 64'd63);
    chk("t1_pow",   64'(bus.peak_pow), 64'd630);
    chk("t1_re",    64'(bus.peak_re),  64'd63);
    chk("t1_im",    64'(bus.peak_im),  64'hFFFF_FFC1);
    chk("t1_found", 64'(bus.peak_found), 64'd1);

    // 2: tie between ch17 and ch40, threshold equal to the peak.
    bus.thresh = 33'd500;
    dv_before = dv_count;
    for (int ch = 0; ch < VL; ch++) begin
      if (ch == 17 || ch == 40) step(1'b1, 1'b0, 32'd250, 32'd250, DW'(ch), '0);
      else                      step(1'b1, 1'b0, 32'd50, 32'd50, DW'(ch), '0);
    end
    idle(4);
    chk("t2_idx",   64'(bus.peak_idx), 64'd17);
    chk("t2_pow",   64'(bus.peak_pow), 64'd500);
    chk("t2_found", 64'(bus.peak_found), 64'd0);
    chk("t2_pulses", 64'(dv_count - dv_before), 64'd1);
    bus.thresh = '0;

    // 3: full-scale powers must not overflow.
    for (int ch = 0; ch < VL; ch++) begin
      if (ch == 5) step(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF);
      else         step(1'b1, 1'b0, '0, '0, '0, '0);
    end
    idle(4);
    chk("t3_idx", 64'(bus.peak_idx), 64'd5);
    chk("t3_pow", 64'(bus.peak_pow), 64'h1_FFFF_FFFE);

    // 4: 50% duty gaps, peak in channel 0.
    dv_before = dv_count;
    for (int ch = 0; ch < VL; ch++) begin
      while ($urandom_range(0, 1) == 0) idle(1);
      if (ch == 0) step(1'b1, 1'b0, 32'd500, 32'd500, 32'd7, 32'd9);
      else step(1'b1, 1'b0, DW'($urandom_range(0, 400)), DW'($urandom_range(0, 400)),
                $urandom, $urandom);
    end
    idle(4);
    chk("t4_idx", 64'(bus.peak_idx), 64'd0);
    chk("t4_pow", 64'(bus.peak_pow), 64'd1000);
    chk("t4_pulses", 64'(dv_count - dv_before), 64'd1);

    // 5: sync at channel 30 aborts; coincident sample becomes channel 0.
    dv_before = dv_count;
    for (int ch = 0; ch < 30; ch++) begin
      if (ch == 10) step(1'b1, 1'b0, 32'd1000, 32'd1000, '0, '0);
      else          step(1'b1, 1'b0, 32'd10, 32'd10, '0, '0);
    end
    step(1'b1, 1'b1, 32'd1500, 32'd1500, 32'd44, 32'd55);
    for (int ch = 1; ch < VL; ch++) step(1'b1, 1'b0, 32'd20, 32'd20, '0, '0);
    idle(4);
    chk("t5_idx", 64'(bus.peak_idx), 64'd0);
    chk("t5_pow", 64'(bus.peak_pow), 64'd3000);
    chk("t5_re",  64'(bus.peak_re),  64'd44);
    chk("t5_pulses", 64'(dv_count - dv_before), 64'd1);

    // 6: reset mid-frame, then back-to-back frames.
    for (int ch = 0; ch < 20; ch++) step(1'b1, 1'b0, 32'd900, 32'd900, '0, '0);
    hold_reset(3);
    chk("t6_pow_after_rst", 64'(bus.peak_pow), 64'd0);
    dv_before = dv_count;
    for (int i = 0; i < 2 * VL; i++)
      step(1'b1, 1'b0, DW'($urandom_range(0, 5000)), DW'($urandom_range(0, 5000)),
           $urandom, $urandom);
    idle(4);
    chk("t6_pulses", 64'(dv_count - dv_before), 64'd2);
    chk("t6_spacing", 64'(last_dv_pc - prev_dv_pc), 64'(VL));

    // Random traffic: gaps, occasional syncs, ties from narrow value ranges.
    bus.thresh = 33'($urandom_range(0, 6));
    for (int i = 0; i < 3000; i++) begin
      if (i < 1500) begin
        a = DW'($urandom_range(0, 3));
        b = DW'($urandom_range(0, 3));
      end else begin
        a = $urandom;
        b = $urandom;
      end
      step($urandom_range(0, 9) < 7, $urandom_range(0, 99) < 2, a, b, $urandom, $urandom);
    end
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
